wr_pkt_admit: RTL

WR_PKT_ADMIT -- requirements
Module: wr_pkt_admit

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/wr_pkt_admit_if.sv | 13 +
 rtl/wr_pkt_admit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the write-side packet admission logic.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int GRAY_MAX_W = 32;

  // Gray-to-binary for any width up to GRAY_MAX_W; bits at or above w are ignored.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int w);
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    for (int i = 0; i < GRAY_MAX_W; i++) gm[i] = (i < w) ? g[i] : 1'b0;
    b[GRAY_MAX_W-1] = gm[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ gm[i];
    return b;
  endfunction

endpackage

// File: rtl/wr_pkt_admit_if.sv
// Upstream packet beat stream with start/end-of-packet markers.
interface wr_pkt_admit_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sop;
    logic              s_eop;

    modport master(output s_valid, s_data, s_sop, s_eop, input s_ready);
    modport slave (input s_valid, s_data, s_sop, s_eop, output s_ready);
endinterface

// File: rtl/wr_pkt_admit.sv
// Admits whole packets into an async FIFO write port only when room for a
// maximum-length packet exists; truncates over-long packets and drops strays.
module wr_pkt_admit
    import fifo_pkg::*;
#(
    parameter int ADDR_LINES = 8,
    parameter int DATA_W     = 8,
    parameter int MAX_PKT    = 16
) (
    input  logic                  wclk,
    input  logic                  wrst,
    wr_pkt_admit_if.slave         s,
    input  logic [ADDR_LINES:0]   wq2_rptr,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_W-1:0]     wdata,
    output logic [ADDR_LINES:0]   wlevel,
    output logic                  trunc_err,
    output logic                  stray_err
);

    localparam int PW = ADDR_LINES + 1;
    localparam int CW = $clog2(MAX_PKT + 1);
    // free >= MAX_PKT+1  <=>  wlevel <= depth - MAX_PKT - 1 (no negative free)
    localparam logic [PW-1:0] LVL_LIMIT = PW'((2 ** ADDR_LINES) - MAX_PKT - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wcnt_q;
    logic [PW-1:0]     wlevel_q, wlevel_d;
    logic              winc_q, wr_d;
    logic [DATA_W-1:0] wdata_q;
    logic              trunc_q, trunc_d;
    logic              stray_q, stray_d;
    logic [PW-1:0]     rptr_bin;
    logic              ready;
    logic              acc;

    assign rptr_bin = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr), PW));
    assign wlevel_d = wcnt_q + PW'(winc_q) - rptr_bin;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        trunc_d = 1'b0;
        stray_d = 1'b0;
        ready   = 1'b0;
        if (wrst) ready = (state_q == IDLE) ? (wlevel_q <= LVL_LIMIT) : 1'b1;
        acc = s.s_valid & ready;
        if (acc) begin
            case (state_q)
                IDLE: begin
                    if (s.s_sop) begin
                        wr_d = 1'b1;
                        if (s.s_eop) begin
                            cnt_d = '0;
                        end else if (MAX_PKT == 1) begin
                            state_d = DROP;
                            trunc_d = 1'b1;
                        end else begin
                            state_d = PASS;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        stray_d = 1'b1;
                    end
                end
                PASS: begin
                    wr_d = 1'b1;
                    if (s.s_eop) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(MAX_PKT - 1)) begin
                        state_d = DROP;
                        cnt_d   = '0;
                        trunc_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DROP: begin
                    if (s.s_eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            wlevel_q <= '0;
            winc_q   <= 1'b0;
            wdata_q  <= '0;
            trunc_q  <= 1'b0;
            stray_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winc_q   <= wr_d;
            wlevel_q <= wlevel_d;
            trunc_q  <= trunc_d;
            stray_q  <= stray_d;
            if (wr_d) wdata_q <= s.s_data;
            if (winc_q && !wfull) wcnt_q <= wcnt_q + PW'(1);
        end
    end

    assign s.s_ready = ready;
    assign winc      = winc_q;
    assign wdata     = wdata_q;
    assign wlevel    = wlevel_q;
    assign trunc_err = trunc_q;
    assign stray_err = stray_q;

endmodule
